// File: rtl/seq_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Optional overflow/divide-by-zero detection is enabled by SEQ_DIV_OVF_EN.
package seq_div_pkg;

    localparam int unsigned SEQ_DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift {a,l} left, trial-subtract the divisor.
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int unsigned W = SEQ_DIV_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] l_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] l_o
);

    logic [W:0] trial;
    logic [W:0] dext;
    logic       ge;

    always_comb begin
        trial = {a_i, l_i[W-1]};
        dext  = {1'b0, d_i};
        ge    = (trial >= dext);
        a_o   = ge ? W'(trial - dext) : trial[W-1:0];
        l_o   = {l_i[W-2:0], ge};
    end

endmodule

// File: rtl/seq_div4.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one bit per clock.
// Define SEQ_DIV_OVF_EN to flag quotient overflow and divide-by-zero at load time.
module seq_div4
    import seq_div_pkg::*;
#(
    parameter int unsigned W = SEQ_DIV_W
) (
    input  logic           CK,
    input  logic           RN,
    input  logic           START,
    input  logic [2*W-1:0] N,
    input  logic [W-1:0]   D,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   R,
    output logic           READY,
    output logic           OVF,
    output logic           DIVZ
);

    localparam int unsigned CW = $clog2(W + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [W-1:0]   a_q,     a_d;
    logic [W-1:0]   l_q,     l_d;
    logic [W-1:0]   dv_q,    dv_d;
    logic           rdy_q,   rdy_d;
    logic           ovf_q,   ovf_d;
    logic           divz_q,  divz_d;

    logic [W-1:0]   step_a;
    logic [W-1:0]   step_l;

    seq_div_step #(.W(W)) u_step (
        .a_i (a_q),
        .l_i (l_q),
        .d_i (dv_q),
        .a_o (step_a),
        .l_o (step_l)
    );

    // Next-state: START always wins; RUN then steps until the last bit is produced.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        l_d     = l_q;
        dv_d    = dv_q;
        rdy_d   = rdy_q;
        ovf_d   = ovf_q;
        divz_d  = divz_q;

        if (START) begin
            a_d     = N[2*W-1:W];
            l_d     = N[W-1:0];
            dv_d    = D;
            cnt_d   = '0;
            state_d = RUN;
            rdy_d   = 1'b0;
`ifdef SEQ_DIV_OVF_EN
            ovf_d   = (N[2*W-1:W] >= D);
            divz_d  = (D == '0);
`else
            ovf_d   = 1'b0;
            divz_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    // An overflowed load skips the iteration and saturates the result.
                    if (ovf_q) begin
                        a_d     = '0;
                        l_d     = '1;
                        state_d = DONE;
                        rdy_d   = 1'b1;
                    end else begin
                        a_d   = step_a;
                        l_d   = step_l;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(W - 1)) begin
                            state_d = DONE;
                            rdy_d   = 1'b1;
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            l_q     <= '0;
            dv_q    <= '0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            l_q     <= l_d;
            dv_q    <= dv_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
            divz_q  <= divz_d;
        end
    end

    assign Q     = l_q;
    assign R     = a_q;
    assign READY = rdy_q;
    assign OVF   = ovf_q;
    assign DIVZ  = divz_q;

endmodule

// File: doc/seq_div4.md
SEQ_DIV4 -- requirements
Module: seq_div4

Interface
REQ-001 SHALL have parameter W, default 4, divisor/quotient/remainder width; dividend is 2*W bits.
REQ-002 SHALL have port CK  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-004 SHALL have port START  input  1  sampled each CK edge; high loads operands and (re)starts a division.
REQ-005 SHALL have port N  input  2*W  unsigned dividend, sampled only on a START edge.
REQ-006 SHALL have port D  input  W  unsigned divisor, sampled only on a START edge.
REQ-007 SHALL have port Q  output  W  quotient.
REQ-008 SHALL have port R  output  W  remainder.
REQ-009 SHALL have port READY  output  1  Q/R/OVF/DIVZ valid.
REQ-010 SHALL have port OVF  output  1  quotient does not fit in W bits.
REQ-011 SHALL have port DIVZ  output  1  divisor is zero.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE, held in a registered state variable plus a step counter of clog2(W+1) bits.
REQ-013 SHALL, on any edge with START=1 in any state: load working remainder A=N[2W-1:W], low register L=N[W-1:0] and D; clear the counter; enter RUN; drive READY=0 after the edge.
REQ-014 SHALL, in RUN, perform one restoring step per edge: shift {A,L} left one bit into a W+1-bit trial; if trial >= D then A=trial-D and L[0]=1, else A=trial[W-1:0] and L[0]=0.
REQ-015 SHALL, after the W-th RUN step, enter DONE and set READY=1; READY rises W edges after the START edge.
REQ-016 SHALL drive Q=L and R=A; both are checked only while READY=1.
REQ-017 SHALL hold Q, R, OVF, DIVZ and READY=1 in DONE until the next START=1 edge or reset.
REQ-018 SHALL, when START stays high for consecutive edges, reload each edge and keep READY=0; the operands sampled on the last START edge are the ones used.
REQ-019 SHALL, on START=1 during RUN, abort the current division with no residual effect on the next result.
REQ-020 SHALL treat START=0 in IDLE as a no-op.

Reset
REQ-021 SHALL, on RN low, immediately force state IDLE, counter 0, A=0, L=0, READY=0, OVF=0 and DIVZ=0, regardless of CK.
REQ-022 SHALL ignore START while RN is low; the first START edge after RN rises SHALL behave as in REQ-013.

Configuration
REQ-023 SHALL support macro SEQ_DIV_OVF_EN to enable overflow detection.
REQ-024 SHALL, with SEQ_DIV_OVF_EN defined, check N[2W-1:W] >= D at the START edge; if true, set OVF=1, set DIVZ=(D==0), set Q to all ones and R to 0, and enter DONE with READY=1 one edge after the START edge, skipping RUN.
REQ-025 SHALL, without SEQ_DIV_OVF_EN, tie OVF and DIVZ to 0 and always run W steps; results for N[2W-1:W] >= D are unspecified.

Structure
REQ-026 SHALL place the state enum typedef and the default W constant in shared package seq_div_pkg.
REQ-027 SHALL implement the shift/trial-subtract as combinational sub-module seq_div_step, instanced once.

Verification
REQ-028 SHALL cover: N=0x64, D=7, START one cycle -> READY rises 4 edges later, Q=0xE, R=0x2, OVF=0.
REQ-029 SHALL cover: N=0x77, D=8 -> Q=0xE, R=0x7; N=0x00, D=1 -> Q=0x0, R=0x0.
REQ-030 SHALL cover, with SEQ_DIV_OVF_EN: N=0x80, D=5 -> READY after 1 edge, OVF=1, DIVZ=0, Q=0xF, R=0x0; and N=0x12, D=0 -> OVF=1, DIVZ=1.
REQ-031 SHALL cover: START with N=0x64, D=7, then START with N=0x2D, D=6 two edges later -> READY 4 edges after the second START, Q=0x7, R=0x3.
REQ-032 SHALL cover: START held high 3 edges with changing operands, last N=0x39, D=5 -> READY=0 throughout, then Q=0xB, R=0x2.
REQ-033 SHALL cover: RN pulsed low mid-RUN -> READY/Q/R/OVF/DIVZ read 0 immediately; the next START with N=0x64, D=7 -> Q=0xE, R=0x2.
